// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle delivery strobe, overrun on a full FIFO.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and add the frame_err output.
module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    input  logic       full,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       overrun
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [12:0] CNT_LAST     = 13'(BAUD_CNT_MAX - 1);
    localparam logic [12:0] CNT_MID      = 13'(BAUD_CNT_MAX / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    logic        rx_dly_q, rx_dly_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  po_data_q, po_data_d;
    logic        po_flag_q, po_flag_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;

    logic start_edge;
    logic mid_bit;
    logic stop_ok;

    assign start_edge = rx_dly_q & ~rx_sync_q;
    assign mid_bit    = (baud_cnt_q == CNT_MID);

`ifdef UART_RX_FRAME_ERR_EN
    assign stop_ok = rx_sync_q;
`else
    assign stop_ok = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        rx_dly_d    = rx_sync_q;
        baud_cnt_d  = (baud_cnt_q == CNT_LAST) ? 13'd0 : baud_cnt_q + 13'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = 13'd0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (mid_bit) begin
                    // A line that is high again at mid-bit was only a glitch.
                    if (rx_sync_q) begin
                        state_d    = IDLE;
                        baud_cnt_d = 13'd0;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (mid_bit) begin
                    state_d    = IDLE;
                    baud_cnt_d = 13'd0;
                    if (!stop_ok) begin
                        frame_err_d = 1'b1;
                    end else if (full) begin
                        overrun_d = 1'b1;
                    end else begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = 13'd0;
            end
        endcase
    end

    // Synchronizer resets high so releasing reset never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_dly_q    <= 1'b1;
            baud_cnt_q  <= 13'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            po_data_q   <= 8'h00;
            po_flag_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_dly_q    <= rx_dly_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign po_data = po_data_q;
    assign po_flag = po_flag_q;
    assign overrun = overrun_q;

`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a short bit period (100 clk/bit) to keep runs small.
// Build with UART_RX_FRAME_ERR_EN defined to exercise the frame_err port.
module tb_uart_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 500_000;
    localparam int BIT      = CLK_FREQ / UART_BPS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic       full      = 1'b0;
    logic [7:0] po_data;
    logic       po_flag;
    logic       overrun;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    uart_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .full      (full),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .overrun   (overrun)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #10 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [7:0]  flag_data[$];
    int unsigned flag_cyc[$];
    int          ovr_cnt  = 0;
    int          fe_cnt   = 0;
    int          both_cnt = 0;

    always @(negedge sys_clk) begin
        if (po_flag) begin
            flag_data.push_back(po_data);
            flag_cyc.push_back(cyc);
        end
        if (overrun) ovr_cnt++;
        if (po_flag && overrun) both_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err) fe_cnt++;
`endif
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Drives one full 8N1 frame; full is raised only in the phases asked for.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic full_stop, input logic full_data);
        full = 1'b0;
        rx   = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            full = full_data;
            rx   = b[i];
            wait_clk(BIT);
        end
        full = full_stop;
        rx   = stop_bit;
        wait_clk(BIT);
        full = 1'b0;
        rx   = 1'b1;
    endtask

    int base;
    int ovr_base;
    int fe_base;

    initial begin
        wait_clk(5);
        check("rst_po_data", 32'(po_data), 32'h00);
        check("rst_po_flag", 32'(po_flag), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
        check("rst_frame_err", 32'(frame_err), 32'h0);
`endif
        sys_rst_n = 1'b1;
        wait_clk(3 * BIT);
        check("no_flag_after_release", 32'(flag_data.size()), 32'd0);

        // Single frame 0x55
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT);
        check("x55_count", 32'(flag_data.size()), 32'd1);
        if (flag_data.size() >= 1) check("x55_data", 32'(flag_data[0]), 32'h55);
        check("x55_held", 32'(po_data), 32'h55);

        // Back-to-back 0xA3, 0x0F: pulses exactly one frame (10 bits) apart
        base = flag_data.size();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT);
        check("b2b_count", 32'(flag_data.size() - base), 32'd2);
        if (flag_data.size() >= base + 2) begin
            check("b2b_first", 32'(flag_data[base]), 32'hA3);
            check("b2b_second", 32'(flag_data[base + 1]), 32'h0F);
            check("b2b_spacing", flag_cyc[base + 1] - flag_cyc[base], 32'(10 * BIT));
        end

        // Short low glitch while idle is a false start
        base = flag_data.size();
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("glitch_no_flag", 32'(flag_data.size() - base), 32'd0);
        check("glitch_po_data", 32'(po_data), 32'h0F);
        // full during data bits only must not matter
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        wait_clk(BIT);
        check("x3c_count", 32'(flag_data.size() - base), 32'd1);
        check("x3c_data", 32'(po_data), 32'h3C);

        // full at the stop sample: overrun instead of delivery
        base     = flag_data.size();
        ovr_base = ovr_cnt;
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        wait_clk(BIT);
        check("x7e_overrun", 32'(ovr_cnt - ovr_base), 32'd1);
        check("x7e_no_flag", 32'(flag_data.size() - base), 32'd0);
        check("x7e_po_data_kept", 32'(po_data), 32'h3C);

        // Bad stop bit
        base    = flag_data.size();
        fe_base = fe_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        wait_clk(BIT);
`ifdef UART_RX_FRAME_ERR_EN
        check("x81_frame_err", 32'(fe_cnt - fe_base), 32'd1);
        check("x81_no_flag", 32'(flag_data.size() - base), 32'd0);
        check("x81_po_data_kept", 32'(po_data), 32'h3C);
`else
        check("x81_flag", 32'(flag_data.size() - base), 32'd1);
        check("x81_data", 32'(po_data), 32'h81);
        check("x81_no_frame_err", 32'(fe_cnt - fe_base), 32'd0);
`endif

        // Reset during data bit 4 of 0xF0 (line stays high from bit 4 on)
        base = flag_data.size();
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            wait_clk(BIT);
        end
        rx = 1'b1;
        wait_clk(30);
        sys_rst_n = 1'b0;
        wait_clk(2);
        check("midrst_po_data", 32'(po_data), 32'h00);
        check("midrst_po_flag", 32'(po_flag), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        wait_clk(5);
        sys_rst_n = 1'b1;
        wait_clk(4 * BIT + BIT - 37);
        wait_clk(BIT);
        check("midrst_no_flag", 32'(flag_data.size() - base), 32'd0);
        check("midrst_po_data_after", 32'(po_data), 32'h00);
        send_frame(8'hC5, 1'b1, 1'b0, 1'b0);
        wait_clk(BIT);
        check("xc5_count", 32'(flag_data.size() - base), 32'd1);
        check("xc5_data", 32'(po_data), 32'hC5);

        check("flag_overrun_exclusive", 32'(both_cnt), 32'd0);
        check("overrun_total", 32'(ovr_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter UART_BPS, default 9600, serial baud rate in bit/s.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 SHALL have port sys_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port full  input  1  downstream receive FIFO full; a byte is not delivered while high.
REQ-007 SHALL have port po_data  output  8  last received byte, held stable until the next delivery.
REQ-008 SHALL have port po_flag  output  1  one-cycle strobe that marks po_data as a new valid byte (FIFO write enable).
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because full is high.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit; exists only when UART_RX_FRAME_ERR_EN is defined.

Function
REQ-011 SHALL compute BAUD_CNT_MAX = CLK_FREQ/UART_BPS (5208 at defaults) and SHALL use a 13-bit baud counter that counts 0..BAUD_CNT_MAX-1 and wraps.
REQ-012 SHALL pass rx through a 2-flop synchronizer plus one delay flop, and SHALL detect a start edge as delayed=1 and synchronized=0.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE: baud counter held at 0; on a start edge, clear the counter and go to START.
REQ-015 SHALL sample each bit when the baud counter equals BAUD_CNT_MAX/2 (mid-bit).
REQ-016 START: at the mid-bit sample, if rx_sync=1 treat it as a false start and return to IDLE with no output; otherwise go to DATA with the bit index set to 0.
REQ-017 DATA: shift 8 mid-bit samples into a shift register, LSB first, and go to STOP after bit index 7.
REQ-018 STOP: at the mid-bit sample, evaluate the stop bit and return to IDLE in the same cycle, so the next start edge is accepted without waiting out the rest of the stop bit.
REQ-019 Good frame with full=0: load po_data and assert po_flag for exactly 1 cycle, on the cycle after the stop-bit sample.
REQ-020 Good frame with full=1 at the stop-bit sample: leave po_data unchanged, keep po_flag at 0, and pulse overrun for 1 cycle at the same latency as po_flag.
REQ-021 The full input SHALL be examined only at the stop-bit sample cycle.
REQ-022 po_flag and overrun SHALL never be asserted in the same cycle.
REQ-023 A falling edge on rx during START, DATA or STOP SHALL NOT restart the frame.

Reset
REQ-024 While sys_rst_n=0: FSM=IDLE, baud counter=0, bit index=0, shift register=0.
REQ-025 While sys_rst_n=0: synchronizer and delay flops=1, so that release of reset never produces a false start edge.
REQ-026 While sys_rst_n=0: po_data=8'h00, po_flag=0, overrun=0, frame_err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without delivering it; after release, reception resumes only on a fresh start edge.

Configuration
REQ-028 Macro UART_RX_FRAME_ERR_EN defined: stop sample=0 SHALL drop the byte, pulse frame_err for 1 cycle at the po_flag latency, and keep po_flag=0 and overrun=0; the frame_err port SHALL exist.
REQ-029 Macro UART_RX_FRAME_ERR_EN undefined: the stop bit SHALL NOT be checked, every frame counts as good (REQ-019/020 apply), and the frame_err port and its logic SHALL be absent.

Verification (defaults, 5208 clk/bit)
REQ-030 Send frame 0x55 with full=0 -> exactly one po_flag pulse, po_data=8'h55, which stays 8'h55 afterwards.
REQ-031 Send 0xA3 then 0x0F back-to-back (no idle between stop and next start) -> two po_flag pulses about 52080 clk apart, values 8'hA3 then 8'h0F.
REQ-032 rx low glitch of 1000 clk while idle -> no po_flag, FSM back in IDLE, and a following 0x3C is received correctly.
REQ-033 Send 0x7E with full=1 during the stop bit -> overrun pulses once, po_flag stays 0, and po_data keeps its previous value.
REQ-034 Send 0x81 with stop bit=0: with UART_RX_FRAME_ERR_EN -> frame_err pulses once and po_flag stays 0; without it -> po_flag pulses and po_data=8'h81.
REQ-035 Assert sys_rst_n low during data bit 4 of a frame, then release -> no po_flag for that frame and all outputs at reset values; a following 0xC5 is received correctly.
